// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite command master.
// Contents:
//   - Bus widths, which are fixed.
//   - AXI response codes and the watchdog read-data pattern.
//   - FSM state encoding.
package axi_lite_pkg;

    localparam int unsigned C_M_AXI_ADDR_WIDTH = 32;
    localparam int unsigned C_M_AXI_DATA_WIDTH = 32;
    localparam int unsigned C_M_AXI_STRB_WIDTH = C_M_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaddrData = 3'd1,
        StWresp     = 3'd2,
        StRaddr     = 3'd3,
        StRdata     = 3'd4,
        StRsp       = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_master_cmd_if.sv
// AXI4-Lite bus bundle between the command master and a memory-mapped slave.
// Modports:
//   master - drives the AW/W/AR address, data and VALID signals plus BREADY/RREADY.
//   slave  - drives AWREADY/WREADY/ARREADY and the B/R response channels.
interface axi_lite_master_cmd_if;
    import axi_lite_pkg::*;

    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr;
    logic                          awvalid;
    logic                          awready;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata;
    logic [C_M_AXI_STRB_WIDTH-1:0] wstrb;
    logic                          wvalid;
    logic                          wready;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr;
    logic                          arvalid;
    logic                          arready;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                    rresp;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding AXI4-Lite master: turns a command/response stream into one AXI4-Lite
// read or write at a time. All outputs are registered; reset is asynchronous, active-low.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN - clock and reset (the slave shares this reset).
//   cmd_*                     - command stream (valid/ready, write flag, address, data, strobes).
//   rsp_*                     - response stream (valid/ready, read data, AXI response code).
//   busy                      - high whenever the FSM is not idle.
//   m_axi                     - AXI4-Lite master-side bus (AW, W, B, AR, R channels).
// Optional build macro AXI_MASTER_TIMEOUT_EN adds a watchdog that abandons a hung transfer
// after C_TIMEOUT_CYCLES cycles and answers with DECERR and the DEADBEEF pattern.
module axi_lite_master_cmd
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR       = 32'h0000_0000,
    parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [31:0]           cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  busy,
    axi_lite_master_cmd_if.master m_axi
);

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_resp_q, rsp_resp_d;
    logic        busy_q, busy_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(C_TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;

        unique case (state_q)
            StIdle: begin
                // cmd_ready is low for the first idle cycle after reset, then stays up.
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = C_BASEADDR + cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWaddrData;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRaddr;
                    end
                end
            end
            StWaddrData: begin
                // AW and W retire independently; a channel already done has VALID low.
                if (m_axi.awready) awvalid_d = 1'b0;
                if (m_axi.wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
                    bready_d = 1'b1;
                    state_d  = StWresp;
                end
            end
            StWresp: begin
                if (m_axi.bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_axi.bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRaddr: begin
                if (m_axi.arready && arvalid_q) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (m_axi.rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = m_axi.rresp;
                    rsp_rdata_d = m_axi.rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready && rsp_valid_q) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef AXI_MASTER_TIMEOUT_EN
        tmo_d = tmo_q;
        if (state_q == StIdle) begin
            tmo_d = '0;
        end else if (state_q != StRsp) begin
            tmo_d = tmo_q + 16'd1;
            // A genuine completion on the expiry cycle still wins over the watchdog.
            if (tmo_q == TmoLast && state_d != StRsp) begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_resp_d  = RESP_DECERR;
                rsp_rdata_d = TIMEOUT_RDATA;
                state_d     = StRsp;
            end
        end
`endif

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Watchdog limit must be at least 2 and fit the 16-bit counter.
    tmo_param_ok: assert property (@(posedge M_AXI_ACLK)
        C_TIMEOUT_CYCLES >= 2 && C_TIMEOUT_CYCLES <= 65536);

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign busy          = busy_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Self-checking bench for axi_lite_master_cmd: a cycle-level AXI4-Lite slave with per-channel
// wait knobs, plus a scoreboard of expected responses popped on each response handshake.
module tb_axi_lite_master_cmd;
    import axi_lite_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int unsigned TMO  = 16;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    axi_lite_master_cmd_if axi ();

    axi_lite_master_cmd #(
        .C_BASEADDR       (BASE),
        .C_TIMEOUT_CYCLES (TMO)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .busy          (busy),
        .m_axi         (axi)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    rsp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Slave knobs and state.
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
    logic [31:0] rdata_cfg = '0;
    bit          proto_en = 1'b1;
    bit          aw_done, w_done, b_sent, ar_done, r_sent;
    int          aw_cnt, w_cnt, ar_cnt, arv_cycles;
    logic [31:0] got_awaddr, got_wdata, got_araddr;
    logic [3:0]  got_wstrb;
    logic        s_awv, s_wv, s_bready, s_arv, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;

    task clear_slave();
        aw_done = 0; w_done = 0; b_sent = 0; ar_done = 0; r_sent = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; arv_cycles = 0;
        got_awaddr = '0; got_wdata = '0; got_araddr = '0; got_wstrb = '0;
    endtask

    // Slave: acts on falling edges; a handshake at the rising edge in between is detected from
    // the VALID/READY values held since the previous falling edge.
    initial begin : slave
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
        s_awv = 0; s_wv = 0; s_bready = 0; s_arv = 0; s_rready = 0;
        s_awaddr = 0; s_wdata = 0; s_araddr = 0; s_wstrb = 0;
        clear_slave();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
                axi.arready = 0; axi.rvalid = 0;
                s_awv = 0; s_wv = 0; s_bready = 0; s_arv = 0; s_rready = 0;
                clear_slave();
            end else begin
                if (s_awv && axi.awready) begin
                    aw_done = 1; axi.awready = 0; got_awaddr = s_awaddr;
                    if (proto_en) check("aw_drop", axi.awvalid, 0);
                end else if (s_awv && proto_en) begin
                    check("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, s_awaddr});
                end
                if (s_wv && axi.wready) begin
                    w_done = 1; axi.wready = 0; got_wdata = s_wdata; got_wstrb = s_wstrb;
                    if (proto_en) check("w_drop", axi.wvalid, 0);
                end else if (s_wv && proto_en) begin
                    check("w_hold", {axi.wvalid, axi.wstrb, axi.wdata}, {1'b1, s_wstrb, s_wdata});
                end
                if (s_bready && axi.bvalid) axi.bvalid = 0;
                if (s_arv && axi.arready) begin
                    ar_done = 1; axi.arready = 0; got_araddr = s_araddr;
                    if (proto_en) check("ar_drop", axi.arvalid, 0);
                end else if (s_arv && proto_en) begin
                    check("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, s_araddr});
                end
                if (s_rready && axi.rvalid) axi.rvalid = 0;
                if (axi.bready && proto_en) check("bready_after_aw_w", {aw_done, w_done}, 2'b11);

                if (axi.awvalid && !aw_done) begin axi.awready = (aw_cnt >= aw_wait); aw_cnt++; end
                if (axi.wvalid && !w_done) begin axi.wready = (w_cnt >= w_wait); w_cnt++; end
                if (axi.arvalid && !ar_done) begin axi.arready = (ar_cnt >= ar_wait); ar_cnt++; end
                if (axi.arvalid) arv_cycles++;
                if (aw_done && w_done && !b_sent) begin
                    axi.bvalid = 1; axi.bresp = bresp_cfg; b_sent = 1;
                end
                if (ar_done && !r_sent) begin
                    axi.rvalid = 1; axi.rdata = rdata_cfg; axi.rresp = rresp_cfg; r_sent = 1;
                end
                s_awv = axi.awvalid; s_wv = axi.wvalid; s_bready = axi.bready;
                s_arv = axi.arvalid; s_rready = axi.rready;
                s_awaddr = axi.awaddr; s_wdata = axi.wdata; s_wstrb = axi.wstrb;
                s_araddr = axi.araddr;
            end
        end
    end

    // Response monitor: pops the scoreboard for each response handshake.
    initial begin : rsp_mon
        rsp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", rsp_resp, e.resp);
                end
            end
        end
    end

    // One full command: issue, observe latency, optionally hold off the response, then check
    // what the slave saw. exp_lat counts cycles from the one right after the accept edge (= 1).
    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_resp, input int exp_lat, input int hold);
        rsp_t        e;
        int          n;
        logic [31:0] ea;
        logic [31:0] held_d;
        logic [1:0]  held_r;
        ea = BASE + addr;
        clear_slave();
        e.rdata = wr ? 32'h0 : exp_rdata;
        e.resp  = exp_resp;
        sb_q.push_back(e);
        rsp_ready = (hold == 0);
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_ready_before_accept", cmd_ready, 1);
        @(negedge clk);
        // Scramble the command inputs; the DUT must ignore them while busy.
        cmd_valid = 0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_wstrb = ~strb;
        check("acc_ready_busy", {cmd_ready, busy}, 2'b01);
        check("acc_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, wr ? 3'b110 : 3'b001);
        n = 1;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        check("rsp_seen", rsp_valid, 1);
        if (exp_lat > 0) check("latency", n, exp_lat);
        if (hold > 0) begin
            held_d = rsp_rdata;
            held_r = rsp_resp;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("bp_hold", {rsp_valid, cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid,
                                  rsp_resp, rsp_rdata}, {5'b10000, held_r, held_d});
            end
            rsp_ready = 1;
        end
        n = 0;
        while (rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("rsp_done_idle", {rsp_valid, cmd_ready, busy}, 3'b010);
        if (exp_resp != RESP_DECERR) begin
            if (wr) begin
                check("awaddr", got_awaddr, ea);
                check("wdata_wstrb", {got_wstrb, got_wdata}, {strb, wdata});
            end else begin
                check("araddr", got_araddr, ea);
            end
        end
    endtask

    initial begin : main
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 1;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {cmd_ready, rsp_valid, busy, axi.awvalid, axi.wvalid, axi.bready,
                           axi.arvalid, axi.rready}, 8'h00);
        #2 rst_n = 1;
        #1 check("rst_rel_before_edge", cmd_ready, 0);
        @(negedge clk);
        check("rst_rel_cmd_ready", {cmd_ready, busy}, 2'b10);

        // Zero-wait write.
        do_cmd(1, 32'h4, 32'h0000_00A5, 4'hF, 0, RESP_OKAY, 3, 0);
        // Zero-wait read.
        rdata_cfg = 32'h0BAD_F00D;
        do_cmd(0, 32'h40, 0, 0, 32'h0BAD_F00D, RESP_OKAY, 3, 0);
        // Read with 5 ARREADY wait cycles.
        ar_wait = 5; rdata_cfg = 32'h1234_5678;
        do_cmd(0, 32'h8, 0, 0, 32'h1234_5678, RESP_OKAY, 8, 0);
        ar_wait = 0;
        // W completes 4 cycles before AW; slave error.
        aw_wait = 4; bresp_cfg = RESP_SLVERR;
        do_cmd(1, 32'h10, 32'hDEAD_0001, 4'b0101, 0, RESP_SLVERR, 7, 0);
        // AW completes before W.
        aw_wait = 0; w_wait = 3; bresp_cfg = RESP_EXOKAY;
        do_cmd(1, 32'h14, 32'h5A5A_A5A5, 4'b1000, 0, RESP_EXOKAY, 6, 0);
        w_wait = 0; bresp_cfg = RESP_OKAY;
        // Response back-pressure for 10 cycles; address wraps modulo 2^32.
        rdata_cfg = 32'hCAFE_F00D; rresp_cfg = RESP_SLVERR;
        do_cmd(0, 32'hC000_0010, 0, 0, 32'hCAFE_F00D, RESP_SLVERR, 3, 10);
        rresp_cfg = RESP_OKAY;

        // Reset in the middle of a read with ARVALID high.
        clear_slave();
        ar_wait = 1000;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check("mid_arvalid", axi.arvalid, 1);
        #2 rst_n = 0;
        #1;
        check("midrst_ctrl", {cmd_ready, rsp_valid, busy, axi.awvalid, axi.wvalid, axi.bready,
                              axi.arvalid, axi.rready}, 8'h00);
        check("midrst_data", |{rsp_rdata, rsp_resp, axi.awaddr, axi.wdata, axi.wstrb,
                               axi.araddr}, 0);
        @(negedge clk);
        ar_wait = 0;
        #2 rst_n = 1;
        @(negedge clk);
        check("midrst_release", {cmd_ready, rsp_valid, busy}, 3'b100);

        // Recovery after reset.
        do_cmd(1, 32'h0, 32'h1357_9BDF, 4'b0011, 0, RESP_OKAY, 3, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
        // Hung slave: ARREADY never rises.
        proto_en = 0; ar_wait = 100000;
        do_cmd(0, 32'h30, 0, 0, TIMEOUT_RDATA, RESP_DECERR, TMO + 1, 0);
        check("tmo_arvalid_cycles", arv_cycles, TMO);
        @(negedge clk);
        #2 rst_n = 0;
        @(negedge clk);
        ar_wait = 0; proto_en = 1;
        #2 rst_n = 1;
        @(negedge clk);
`endif

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_cmd.md
Name: axi_lite_master_cmd

Overview:
- Single-outstanding AXI4-Lite master (initiator) that turns a simple command/response stream into AXI4-Lite transactions.
- Drives the memory-mapped slaves on the mach AXI-Lite bus, such as the UARTLite wrapper, from a sequencer or debug bridge.
- Handles one read or one write at a time.
- Returns read data and the AXI response code on a response stream.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width; localparam, fixed.
- C_M_AXI_DATA_WIDTH, 32, data width; localparam, fixed.
- C_BASEADDR, 32'h00000000, added to cmd_addr (modulo 2^32) to form AWADDR/ARADDR.
- C_TIMEOUT_CYCLES, 1024, watchdog limit; used only with AXI_MASTER_TIMEOUT_EN; must be >= 2.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address offset.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or timeout code.
- busy  out  1  high in any state other than IDLE.
- M_AXI_AWADDR out 32 / M_AXI_AWVALID out 1 / M_AXI_AWREADY in 1: write address channel.
- M_AXI_WDATA out 32 / M_AXI_WSTRB out 4 / M_AXI_WVALID out 1 / M_AXI_WREADY in 1: write data channel.
- M_AXI_BRESP in 2 / M_AXI_BVALID in 1 / M_AXI_BREADY out 1: write response channel.
- M_AXI_ARADDR out 32 / M_AXI_ARVALID out 1 / M_AXI_ARREADY in 1: read address channel.
- M_AXI_RDATA in 32 / M_AXI_RRESP in 2 / M_AXI_RVALID in 1 / M_AXI_RREADY out 1: read data channel.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - Every output is registered.
  - While M_AXI_ARESETN = 0, all outputs are 0, including cmd_ready, and the FSM is IDLE.
  - cmd_ready rises on the first clock edge after reset release.
- FSM states: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On accept, cmd_ready drops next cycle; address, data and strobes are latched.
  - Write goes to WADDR_DATA. AWVALID and WVALID both rise on the cycle after accept, giving latency 1.
  - Read goes to RADDR. ARVALID rises on the cycle after accept.
- WADDR_DATA:
  - AWVALID and WVALID each drop independently on the cycle after their own handshake.
  - AW and W may complete in the same cycle or in either order.
  - When both are done, go to WRESP with BREADY = 1.
  - AWADDR, WDATA and WSTRB stay stable while their VALID is high.
- WRESP:
  - On BVALID && BREADY, capture BRESP, set rsp_rdata = 0, drop BREADY, go to RSP.
- RADDR:
  - On ARVALID && ARREADY, drop ARVALID, raise RREADY, go to RDATA.
- RDATA:
  - On RVALID && RREADY, capture RDATA and RRESP, drop RREADY, go to RSP.
- RSP:
  - rsp_valid = 1; rsp_rdata and rsp_resp are held stable until rsp_ready.
  - On handshake, rsp_valid drops and the FSM returns to IDLE. cmd_ready rises the same edge.
  - rsp_ready is ignored while rsp_valid = 0.
- Handshake rules:
  - No VALID is ever withdrawn before its handshake, except on watchdog timeout.
  - No VALID depends combinationally on a slave READY.
- Command protocol and reset:
  - Inputs are sampled only at accept; changes to cmd_* during busy are ignored.
  - Reset asserted mid-transaction aborts immediately: all VALID/READY go low and no response is issued.
  - The slave must be reset by the same signal.
- Best-case cycle counts, accept edge to rsp_valid, with the slave ready-high and zero-wait:
  - Write: 3 cycles.
  - Read: 3 cycles.

Optional Feature:
- Macro: AXI_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on accept and increments each cycle in WADDR_DATA, WRESP, RADDR and RDATA.
  - When the count reaches C_TIMEOUT_CYCLES, all M_AXI VALID/READY outputs drop and the FSM enters RSP.
  - The timeout response is rsp_resp = 2'b11 and rsp_rdata = 32'hDEADBEEF.
  - This intentionally breaks the protocol; it exists for absent or hung slaves only, and the bus requires reset afterwards.
- Undefined:
  - No counter exists and the block waits indefinitely.

Decomposition:
- Shared package axi_lite_pkg holds:
  - Response constants: RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - Timeout data constant: TIMEOUT_RDATA = 32'hDEADBEEF.
  - FSM state encoding.
- No sub-module; the single FSM plus datapath registers stays flat.

Test Plan:
- Write, zero-wait slave: cmd_write=1, cmd_addr=4, cmd_wdata=32'h000000A5, cmd_wstrb=4'hF → AWADDR=C_BASEADDR+4 and WDATA=32'hA5; rsp_valid 3 cycles after accept with rsp_resp=0 and rsp_rdata=0.
- Read: slave returns RDATA=32'h12345678, RRESP=0 after 5 ARREADY wait cycles → ARVALID held stable for all 5 cycles; rsp_rdata=32'h12345678.
- Skewed write: WREADY 4 cycles before AWREADY → WVALID drops early, BREADY rises only after the AW handshake; BRESP=2'b10 → rsp_resp=2'b10.
- Response backpressure: rsp_ready held 0 for 10 cycles → rsp_valid and rsp_rdata stable throughout, cmd_ready stays 0, no new AXI VALID asserted.
- Reset mid-read: ARESETN low while ARVALID=1 → every output 0 asynchronously, before the next edge; cmd_ready=1 one edge after release.
- Timeout, AXI_MASTER_TIMEOUT_EN with C_TIMEOUT_CYCLES=16: ARREADY stuck at 0 → ARVALID drops after 16 cycles; rsp_resp=2'b11 and rsp_rdata=32'hDEADBEEF.
